usb_device_responder: RTL and testbench

Device-side endpoint of the serial USB link. It receives host token packets on the DP/DM pair, undoes NRZI and bit stuffing, and validates PID and CRC5. It reports OUT, IN and SETUP tokens to the device protocol logic. For IN tokens it drives a handshake packet (ACK, NAK or STALL) back onto the bus. It is the receive-then-respond counterpart to the host-side encode, stuff, NRZI and DPDM datapath, and serves as the device model on the host bench.

---
 rtl/usb_device_responder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_usb_device_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_device_responder.sv
// Device-side USB token receiver (NRZI/unstuff/PID/CRC5) with IN handshake responder.
// Define USB_RESP_CRC5_CHECK_EN to enable CRC5 checking; otherwise CRC bits are consumed unchecked.
module usb_device_responder #(
  parameter logic [6:0] DEV_ADDR = 7'd5,
  parameter int         TURN     = 4
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       dp_r,
  input  logic       dm_r,
  output logic       dp_w,
  output logic       dm_w,
  output logic       drive_en,
  input  logic [3:0] hs_pid,
  output logic       tok_valid,
  output logic [3:0] tok_pid,
  output logic [6:0] tok_addr,
  output logic [3:0] tok_endp,
  output logic       crc_err,
  output logic       rx_err,
  output logic [3:0] fsm_state
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_SYNC    = 4'd1;
  localparam logic [3:0] S_PID     = 4'd2;
  localparam logic [3:0] S_BODY    = 4'd3;
  localparam logic [3:0] S_EOP     = 4'd4;
  localparam logic [3:0] S_TURN    = 4'd5;
  localparam logic [3:0] S_TX_SYNC = 4'd6;
  localparam logic [3:0] S_TX_PID  = 4'd7;
  localparam logic [3:0] S_TX_EOP  = 4'd8;
  localparam logic [3:0] S_ERR     = 4'd9;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] TURN_LAST = 4'(TURN - 1);

  // Handshake: valid/ready is not used; tok_valid, crc_err and rx_err are
  // single-cycle strobes with no back-pressure, and tok_* hold until the next accepted token.

  logic [3:0]  state;
  logic [3:0]  cnt;
  logic [2:0]  ones;
  logic        level;      // last received line level, 1 = J
  logic [7:0]  pid_sr;
  logic [10:0] body_sr;
  logic [4:0]  crc;
  logic [3:0]  hs_q;

  logic        line_j, line_k, line_se0, line_jk;
  logic        rx_bit, stuff_slot, pid_ok, hs_ok, crc_ok, sync_exp_j;
  logic        fault, tx_bit, tx_dp, tx_sync_j;
  logic [7:0]  pid_byte, tx_byte;
  logic [4:0]  crc_next;
  logic [2:0]  tx_idx;

  assign fsm_state  = state;
  assign line_j     = dp_r & ~dm_r;
  assign line_k     = ~dp_r & dm_r;
  assign line_se0   = ~dp_r & ~dm_r;
  assign line_jk    = line_j | line_k;
  assign rx_bit     = line_j ? level : ~level;
  assign stuff_slot = (ones == 3'd6);
  assign pid_byte   = {rx_bit, pid_sr[7:1]};
  assign pid_ok     = (pid_byte[7:4] == ~pid_byte[3:0]) &&
                      ((pid_byte[3:0] == PID_OUT) || (pid_byte[3:0] == PID_IN) ||
                       (pid_byte[3:0] == PID_SETUP));
  assign hs_ok      = (hs_pid == 4'b0010) || (hs_pid == 4'b1010) || (hs_pid == 4'b1110);
  assign crc_next   = {crc[3:0], 1'b0} ^ ((rx_bit ^ crc[4]) ? 5'b00101 : 5'b00000);
  assign sync_exp_j = (cnt == 4'd1) || (cnt == 4'd3) || (cnt == 4'd5);
  assign tx_sync_j  = (cnt == 4'd0) || (cnt == 4'd2) || (cnt == 4'd4);
  assign tx_byte    = {~hs_q, hs_q};
  assign tx_idx     = cnt[2:0] + 3'd1;
  assign tx_bit     = (state == S_TX_SYNC) ? tx_byte[0] : tx_byte[tx_idx];
  assign tx_dp      = tx_bit ? dp_w : ~dp_w;   // NRZI: a 0 toggles the line

`ifdef USB_RESP_CRC5_CHECK_EN
  assign crc_ok = (crc == 5'b01100);
`else
  logic crc_unused;
  assign crc_unused = ^crc;
  assign crc_ok     = 1'b1;
`endif

  // Receive-side framing faults; any of these sends the FSM to ERR.
  always_comb begin
    fault = 1'b0;
    case (state)
      S_SYNC:         fault = !(line_jk && (line_j == sync_exp_j));
      S_PID, S_BODY:  fault = !line_jk || (stuff_slot && rx_bit) ||
                              ((state == S_PID) && !stuff_slot && (cnt == 4'd7) && !pid_ok);
      S_EOP: begin
        case (cnt)
          4'd0:    fault = !(line_se0 || (line_jk && stuff_slot && !rx_bit));
          4'd1:    fault = !line_se0;
          4'd2:    fault = !line_j;
          default: fault = 1'b1;
        endcase
      end
      default:        fault = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ones      <= '0;
      level     <= 1'b1;
      pid_sr    <= '0;
      body_sr   <= '0;
      crc       <= 5'b11111;
      hs_q      <= '0;
      dp_w      <= 1'b1;
      dm_w      <= 1'b0;
      drive_en  <= 1'b0;
      tok_valid <= 1'b0;
      tok_pid   <= '0;
      tok_addr  <= '0;
      tok_endp  <= '0;
      crc_err   <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      tok_valid <= 1'b0;
      crc_err   <= 1'b0;
      rx_err    <= 1'b0;
      if (fault) begin
        state  <= S_ERR;
        cnt    <= '0;
        rx_err <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            level <= 1'b1;
            if (line_k) begin
              state <= S_SYNC;
              cnt   <= 4'd1;
            end
          end
          S_SYNC: begin
            if (cnt == 4'd7) begin
              state <= S_PID;
              cnt   <= '0;
              ones  <= 3'd1;   // the closing KK is already one 1 toward stuffing
              level <= 1'b0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          S_PID, S_BODY: begin
            level <= line_j;
            if (stuff_slot) begin
              ones <= '0;
            end else begin
              ones <= rx_bit ? ones + 3'd1 : 3'd0;
              cnt  <= cnt + 4'd1;
              if (state == S_PID) begin
                pid_sr <= pid_byte;
                if (cnt == 4'd7) begin
                  state <= S_BODY;
                  cnt   <= '0;
                  crc   <= 5'b11111;
                end
              end else begin
                crc <= crc_next;
                if (cnt < 4'd11) body_sr <= {rx_bit, body_sr[10:1]};
                if (cnt == 4'd15) begin
                  state <= S_EOP;
                  cnt   <= '0;
                end
              end
            end
          end
          S_EOP: begin
            if (cnt == 4'd0) begin
              if (line_se0) begin
                cnt <= 4'd1;
              end else begin
                ones  <= '0;   // trailing stuff bit after the last CRC bit
                level <= line_j;
              end
            end else if (cnt == 4'd1) begin
              cnt <= 4'd2;
            end else begin
              state <= S_IDLE;
              cnt   <= '0;
              level <= 1'b1;
              if (!crc_ok) begin
                crc_err <= 1'b1;
              end else if (body_sr[6:0] == DEV_ADDR) begin
                tok_valid <= 1'b1;
                tok_pid   <= pid_sr[3:0];
                tok_addr  <= body_sr[6:0];
                tok_endp  <= body_sr[10:7];
                hs_q      <= hs_pid;
                if ((pid_sr[3:0] == PID_IN) && hs_ok) state <= S_TURN;
              end
            end
          end
          S_TURN: begin
            if (cnt == TURN_LAST) begin
              state    <= S_TX_SYNC;
              cnt      <= '0;
              drive_en <= 1'b1;
              dp_w     <= 1'b0;
              dm_w     <= 1'b1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          S_TX_SYNC: begin
            if (cnt == 4'd7) begin
              state <= S_TX_PID;
              cnt   <= '0;
              dp_w  <= tx_dp;
              dm_w  <= ~tx_dp;
            end else begin
              cnt  <= cnt + 4'd1;
              dp_w <= tx_sync_j;
              dm_w <= ~tx_sync_j;
            end
          end
          S_TX_PID: begin
            if (cnt == 4'd7) begin
              state <= S_TX_EOP;
              cnt   <= '0;
              dp_w  <= 1'b0;
              dm_w  <= 1'b0;
            end else begin
              cnt  <= cnt + 4'd1;
              dp_w <= tx_dp;
              dm_w <= ~tx_dp;
            end
          end
          S_TX_EOP: begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd1) begin
              dp_w <= 1'b1;
            end else if (cnt == 4'd2) begin
              state    <= S_IDLE;
              cnt      <= '0;
              drive_en <= 1'b0;
              level    <= 1'b1;
            end
          end
          S_ERR: begin
            if (line_j) begin
              if (cnt == 4'd7) begin
                state <= S_IDLE;
                cnt   <= '0;
                level <= 1'b1;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end else begin
              cnt <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_device_responder.sv
// Bench for usb_device_responder: host-side frame encoder, output monitor,
// expected-queue scoreboard for handshake symbols and directed plus random token cases.
module tb_usb_device_responder;

  localparam int         TURN     = 4;
  localparam logic [6:0] DEV_ADDR = 7'd5;
  localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00;
  localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_SETUP = 4'b1101;
  localparam logic [3:0] H_ACK = 4'b0010, H_NAK = 4'b1010, H_STALL = 4'b1110;
`ifdef USB_RESP_CRC5_CHECK_EN
  localparam bit CRC_CHECKED = 1'b1;
`else
  localparam bit CRC_CHECKED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       dp_r = 1'b1, dm_r = 1'b0;
  logic       dp_w, dm_w, drive_en;
  logic [3:0] hs_pid = 4'b0000;
  logic       tok_valid, crc_err, rx_err;
  logic [3:0] tok_pid, tok_endp, fsm_state;
  logic [6:0] tok_addr;

  usb_device_responder #(.DEV_ADDR(DEV_ADDR), .TURN(TURN)) dut (
    .clk(clk), .rst_b(rst_b), .dp_r(dp_r), .dm_r(dm_r),
    .dp_w(dp_w), .dm_w(dm_w), .drive_en(drive_en), .hs_pid(hs_pid),
    .tok_valid(tok_valid), .tok_pid(tok_pid), .tok_addr(tok_addr), .tok_endp(tok_endp),
    .crc_err(crc_err), .rx_err(rx_err), .fsm_state(fsm_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // monitor: collects output events, never compares
  int         tv_cnt = 0, ce_cnt = 0, re_cnt = 0, tv_time = 0, de_rise = 0;
  logic [14:0] last_tok = '0;
  logic [1:0] obs_q[$];
  logic       de_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_b) begin
      if (tok_valid) begin
        tv_cnt++;
        last_tok = {tok_pid, tok_addr, tok_endp};
        tv_time  = cyc;
      end
      if (crc_err) ce_cnt++;
      if (rx_err) re_cnt++;
      if (drive_en) begin
        obs_q.push_back({dp_w, dm_w});
        if (!de_prev) de_rise = cyc;
      end
    end
    de_prev = drive_en;
  end

  // scoreboard state
  int         vectors = 0, miscompares = 0;
  logic [1:0] exp_q[$];
  logic [1:0] tx_q[$];
  int         eop_j_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hs_valid(input logic [3:0] h);
    return (h == H_ACK) || (h == H_NAK) || (h == H_STALL);
  endfunction

  // CRC5 by polynomial long division: init 11111 equals inverting the first five
  // message bits; remainder is transmitted inverted, highest degree first.
  function automatic logic [4:0] crc5_tx(input logic [10:0] d);
    bit s[16];
    logic [4:0] r;
    for (int i = 0; i < 16; i++) s[i] = (i < 11) ? d[i] : 1'b0;
    for (int i = 0; i < 5; i++) s[i] = ~s[i];
    for (int i = 0; i < 11; i++) begin
      if (s[i]) begin
        s[i] = ~s[i]; s[i+3] = ~s[i+3]; s[i+5] = ~s[i+5];
      end
    end
    for (int i = 0; i < 5; i++) r[4-i] = ~s[11+i];
    return r;
  endfunction

  task automatic push_sync(inout logic [1:0] q[$]);
    for (int i = 0; i < 8; i++) q.push_back((i == 1 || i == 3 || i == 5) ? LJ : LK);
  endtask

  // host encoder: SYNC, PID, addr, endp, CRC5, stuffing, NRZI, EOP
  task automatic build_frame(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                             input bit flip, input bit stuff_en);
    bit bits[$];
    logic [7:0] pb;
    logic [4:0] c;
    int ones;
    logic lvl;
    tx_q.delete();
    pb = {~pid, pid};
    for (int i = 0; i < 8; i++) bits.push_back(pb[i]);
    for (int i = 0; i < 7; i++) bits.push_back(addr[i]);
    for (int i = 0; i < 4; i++) bits.push_back(endp[i]);
    c = crc5_tx({endp, addr});
    if (flip) begin
      int k;
      k = $urandom_range(0, 4);
      c[k] = ~c[k];
    end
    for (int i = 4; i >= 0; i--) bits.push_back(c[i]);
    push_sync(tx_q);
    lvl = 1'b0;
    ones = 1;
    foreach (bits[i]) begin
      if (!bits[i]) lvl = ~lvl;
      tx_q.push_back(lvl ? LJ : LK);
      ones = bits[i] ? ones + 1 : 0;
      if (stuff_en && ones == 6) begin
        lvl = ~lvl;
        tx_q.push_back(lvl ? LJ : LK);
        ones = 0;
      end
    end
    tx_q.push_back(LSE0);
    tx_q.push_back(LSE0);
    tx_q.push_back(LJ);
  endtask

  // driver: one symbol per cycle, then idle J
  task automatic send_frame(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                            input bit flip, input bit stuff_en, input int tail);
    build_frame(pid, addr, endp, flip, stuff_en);
    foreach (tx_q[i]) begin
      @(negedge clk);
      {dp_r, dm_r} = tx_q[i];
      eop_j_cyc = cyc;
    end
    repeat (tail) begin
      @(negedge clk);
      {dp_r, dm_r} = LJ;
    end
  endtask

  task automatic build_hs(input logic [3:0] hs);
    logic [7:0] b;
    logic lvl;
    exp_q.delete();
    push_sync(exp_q);
    b = {~hs, hs};
    lvl = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!b[i]) lvl = ~lvl;
      exp_q.push_back(lvl ? LJ : LK);
    end
    exp_q.push_back(LSE0);
    exp_q.push_back(LSE0);
    exp_q.push_back(LJ);
  endtask

  // one well-framed token with full outcome checking against the model
  task automatic token_case(input string name, input logic [3:0] pid, input logic [6:0] addr,
                            input logic [3:0] endp, input bit flip, input logic [3:0] hs);
    int b_tv, b_ce, b_re, b_obs;
    bit good_crc, exp_acc, exp_hs;
    b_tv = tv_cnt; b_ce = ce_cnt; b_re = re_cnt; b_obs = obs_q.size();
    good_crc = !flip || !CRC_CHECKED;
    exp_acc  = good_crc && (addr == DEV_ADDR);
    exp_hs   = exp_acc && (pid == P_IN) && hs_valid(hs);
    hs_pid = hs;
    send_frame(pid, addr, endp, flip, 1'b1, 40);
    chk({name, " tok_valid_n"}, tv_cnt - b_tv, exp_acc ? 1 : 0);
    chk({name, " crc_err_n"}, ce_cnt - b_ce, (flip && CRC_CHECKED) ? 1 : 0);
    chk({name, " rx_err_n"}, re_cnt - b_re, 0);
    if (exp_acc) begin
      chk({name, " tok_fields"}, last_tok, {pid, addr, endp});
      chk({name, " tok_time"}, tv_time, eop_j_cyc + 1);
    end
    chk({name, " drive_cycles"}, obs_q.size() - b_obs, exp_hs ? 19 : 0);
    if (exp_hs && (obs_q.size() - b_obs) == 19) begin
      build_hs(hs);
      chk({name, " turnaround"}, de_rise - tv_time, TURN);
      for (int i = 0; i < 19; i++)
        chk($sformatf("%s hs_sym%0d", name, i), obs_q[b_obs + i], exp_q.pop_front());
    end
    chk({name, " idle_after"}, fsm_state, 4'd0);
  endtask

  initial begin
    int b_tv, b_re, waited;
    logic [3:0] pids[3];
    pids[0] = P_OUT; pids[1] = P_IN; pids[2] = P_SETUP;

    // reset values
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst drive_en", drive_en, 0);
    chk("rst dp_w", dp_w, 1);
    chk("rst dm_w", dm_w, 0);
    chk("rst tok_valid", tok_valid, 0);
    chk("rst crc_err", crc_err, 0);
    chk("rst rx_err", rx_err, 0);
    chk("rst tok_pid", tok_pid, 0);
    chk("rst tok_addr", tok_addr, 0);
    chk("rst tok_endp", tok_endp, 0);
    chk("rst state", fsm_state, 0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (4) @(negedge clk);

    // directed cases
    token_case("in_nak", P_IN, 7'd5, 4'd1, 1'b0, H_NAK);
    token_case("setup", P_SETUP, 7'd5, 4'd0, 1'b0, H_ACK);
    token_case("in_addr3", P_IN, 7'd3, 4'd1, 1'b0, H_ACK);
    token_case("in_crcbad", P_IN, 7'd5, 4'd2, 1'b1, H_ACK);
    token_case("in_nohs", P_IN, 7'd5, 4'd7, 1'b0, 4'b0000);
    token_case("out_stall", P_OUT, 7'd5, 4'hF, 1'b0, H_STALL);

    // stuff error, then a token inside the 8-J recovery window is dropped
    b_tv = tv_cnt; b_re = re_cnt;
    send_frame(P_SETUP, 7'h7F, 4'd0, 1'b0, 1'b0, 3);
    chk("stuff rx_err_n", re_cnt - b_re, 1);
    chk("stuff tok_n", tv_cnt - b_tv, 0);
    send_frame(P_SETUP, 7'd5, 4'd3, 1'b0, 1'b1, 40);
    chk("recover tok_n", tv_cnt - b_tv, 0);
    chk("recover rx_err_n", re_cnt - b_re, 1);
    chk("recover idle", fsm_state, 0);
    token_case("after_err", P_SETUP, 7'd5, 4'd3, 1'b0, H_ACK);

    // randomized tokens
    for (int n = 0; n < 16; n++) begin
      logic [3:0] hs;
      case ($urandom_range(0, 4))
        0: hs = H_ACK;
        1: hs = H_NAK;
        2: hs = H_STALL;
        3: hs = 4'b0000;
        default: hs = 4'($urandom_range(0, 15));
      endcase
      token_case($sformatf("rnd%0d", n), pids[$urandom_range(0, 2)],
                 $urandom_range(0, 1) ? DEV_ADDR : 7'($urandom_range(0, 127)),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), hs);
    end

    // reset during TX_PID bit 3
    hs_pid = H_ACK;
    send_frame(P_IN, 7'd5, 4'd4, 1'b0, 1'b1, 0);
    waited = 0;
    while (!drive_en && waited < 40) begin
      @(negedge clk);
      {dp_r, dm_r} = LJ;
      waited++;
    end
    chk("rstmid drive_seen", drive_en, 1);
    repeat (11) @(negedge clk);
    chk("rstmid pre drive_en", drive_en, 1);
    rst_b = 1'b0;
    #1;
    chk("rstmid drive_en", drive_en, 0);
    chk("rstmid dp_w", dp_w, 1);
    chk("rstmid dm_w", dm_w, 0);
    chk("rstmid state", fsm_state, 0);
    chk("rstmid tok_valid", tok_valid, 0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    token_case("post_rst", P_IN, 7'd5, 4'd4, 1'b0, H_STALL);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
